// File: rtl/sr_flag_arbiter_if.sv
// Request/response bundle between requesters and the SR flag arbiter.
// The master side raises set/clear requests; the slave side drives the flag and handshake.
interface sr_flag_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] set_req;
  logic [N-1:0] clr_req;
  logic         s;
  logic         r;
  logic         q;
  logic         qn;
  logic [N-1:0] grant;
  logic         busy;
  logic         err;

  modport master (
    output set_req, clr_req,
    input  s, r, q, qn, grant, busy, err
  );

  modport slave (
    input  set_req, clr_req,
    output s, r, q, qn, grant, busy, err
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/clear requests from N requesters onto one
// SR-style flag, pulsing s or r for HOLD cycles and returning a one-hot grant.
module sr_flag_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input logic               clk,
  input logic               rst,
  sr_flag_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          op;
  logic [3:0]    cnt;
  logic          q_r;
  logic          err_r;

  logic [N-1:0]  elig;
  logic [N-1:0]  conflict;
  logic          any_elig;
  logic          s_d;
  logic          r_d;
  logic [N-1:0]  grant_d;

  // A requester asking for both set and clear is illegal and never eligible.
  assign conflict = bus.set_req & bus.clr_req;
  assign elig     = bus.set_req ^ bus.clr_req;
  assign any_elig = |elig;

  // Scan from the farthest candidate back toward ptr so the nearest eligible one wins.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (elig[idx]) begin
        pick = idx;
      end
    end
  end

  // Stage: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_elig) state_nxt = DRIVE;
      DRIVE:   if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: service context (selected requester, operation, hold count, rotation pointer)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      sel <= '0;
      op  <= 1'b0;
      cnt <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_elig) begin
            sel <= pick;
            op  <= bus.set_req[pick];
            cnt <= 4'(HOLD - 1);
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ptr <= IW'((int'(sel) + 1) % N);
        end
        default: begin
        end
      endcase
    end
  end

  // s/r come purely from registered state, so they can never overlap or glitch.
  assign s_d = (state == DRIVE) &&  op;
  assign r_d = (state == DRIVE) && !op;

  always_comb begin
    grant_d = '0;
    if (state == DONE) begin
      grant_d[sel] = 1'b1;
    end
  end

  // Stage: SR storage element and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (s_d && !r_d) begin
      q_r <= 1'b1;
    end else if (r_d && !s_d) begin
      q_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (|conflict) begin
      err_r <= 1'b1;
    end
  end

  assign bus.s     = s_d;
  assign bus.r     = r_d;
  assign bus.q     = q_r;
  assign bus.qn    = ~q_r;
  assign bus.grant = grant_d;
  assign bus.busy  = (state != IDLE);
  assign bus.err   = err_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: two instances (HOLD=1 and HOLD=3) share stimulus and are
// compared every cycle against a service-phase reference model.
module tb_sr_flag_arbiter;

  localparam int N     = 4;
  localparam int HOLD0 = 1;
  localparam int HOLD1 = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.N(N)) bus0 ();
  sr_flag_arbiter_if #(.N(N)) bus1 ();

  sr_flag_arbiter #(.N(N), .HOLD(HOLD0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sr_flag_arbiter #(.N(N), .HOLD(HOLD1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1..hold = driving, hold+1 = granting.
  int   m_hold  [2];
  int   m_phase [2];
  int   m_sel   [2];
  int   m_ptr   [2];
  logic m_op    [2];
  logic m_q     [2];
  logic m_err   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_driving(input int k);
    return (m_phase[k] >= 1) && (m_phase[k] <= m_hold[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_sel[k]   = 0;
      m_ptr[k]   = 0;
      m_op[k]    = 1'b0;
      m_q[k]     = 1'b0;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] sr, input logic [N-1:0] cr);
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] el;
      bit found;
      int cand;
      el = sr ^ cr;
      if ((sr & cr) != '0) m_err[k] = 1'b1;
      if (m_driving(k)) m_q[k] = m_op[k];
      if (m_phase[k] == 0) begin
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          cand = (m_ptr[k] + j) % N;
          if (!found && el[cand]) begin
            found    = 1'b1;
            m_sel[k] = cand;
          end
        end
        if (found) begin
          m_op[k]    = sr[m_sel[k]];
          m_phase[k] = 1;
        end
      end else if (m_phase[k] <= m_hold[k]) begin
        m_phase[k] = m_phase[k] + 1;
      end else begin
        m_ptr[k]   = (m_sel[k] + 1) % N;
        m_phase[k] = 0;
      end
    end
  endtask

  task automatic check_inst(input string ph, input int k,
                            input logic s, input logic r, input logic q, input logic qn,
                            input logic busy, input logic err, input logic [N-1:0] grant);
    logic [N-1:0] eg;
    eg = '0;
    if (m_phase[k] == m_hold[k] + 1) eg[m_sel[k]] = 1'b1;
    chk($sformatf("%s/i%0d/s", ph, k),     32'(s),     32'(m_driving(k) && m_op[k]));
    chk($sformatf("%s/i%0d/r", ph, k),     32'(r),     32'(m_driving(k) && !m_op[k]));
    chk($sformatf("%s/i%0d/s_and_r", ph, k), 32'(s & r), 32'(0));
    chk($sformatf("%s/i%0d/q", ph, k),     32'(q),     32'(m_q[k]));
    chk($sformatf("%s/i%0d/qn", ph, k),    32'(qn),    32'(!m_q[k]));
    chk($sformatf("%s/i%0d/busy", ph, k),  32'(busy),  32'(m_phase[k] != 0));
    chk($sformatf("%s/i%0d/err", ph, k),   32'(err),   32'(m_err[k]));
    chk($sformatf("%s/i%0d/grant", ph, k), 32'(grant), 32'(eg));
  endtask

  task automatic check_all(input string ph);
    check_inst(ph, 0, bus0.s, bus0.r, bus0.q, bus0.qn, bus0.busy, bus0.err, bus0.grant);
    check_inst(ph, 1, bus1.s, bus1.r, bus1.q, bus1.qn, bus1.busy, bus1.err, bus1.grant);
  endtask

  task automatic drive(input logic [N-1:0] sr, input logic [N-1:0] cr);
    bus0.set_req = sr;
    bus0.clr_req = cr;
    bus1.set_req = sr;
    bus1.clr_req = cr;
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(bus0.set_req, bus0.clr_req);
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock arrives.
  task automatic pulse_reset(input string ph);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    cycle(ph);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rs;
    logic [N-1:0] rc;
    m_hold[0] = HOLD0;
    m_hold[1] = HOLD1;
    drive('0, '0);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("reset");
    cycle("reset_edge");
    rst = 1'b0;

    // Single set request
    drive(4'b0001, 4'b0000);
    cycle("single_accept");
    drive(4'b0000, 4'b0000);
    repeat (7) cycle("single");

    // All requesters set continuously: round-robin rotation
    drive(4'b1111, 4'b0000);
    repeat (16) cycle("rr");
    drive(4'b0000, 4'b0000);
    repeat (6) cycle("rr_drain");

    // Set and clear contention from different requesters
    pulse_reset("cont_rst");
    drive(4'b0010, 4'b0100);
    repeat (12) cycle("contention");
    drive(4'b0000, 4'b0000);
    repeat (6) cycle("cont_drain");

    // Illegal request: sticky err, no service
    pulse_reset("ill_rst");
    drive(4'b0001, 4'b0001);
    repeat (4) cycle("illegal");
    drive(4'b0000, 4'b0000);
    repeat (4) cycle("illegal_after");

    // Clear with q=1, then abort a service with reset during the second drive cycle
    pulse_reset("hold_rst");
    drive(4'b0001, 4'b0000);
    cycle("hold_set_acc");
    drive(4'b0000, 4'b0000);
    repeat (6) cycle("hold_set");
    drive(4'b0000, 4'b0001);
    cycle("hold_clr_acc");
    drive(4'b0000, 4'b0000);
    repeat (6) cycle("hold_clr");
    drive(4'b0001, 4'b0000);
    cycle("abort_set_acc");
    drive(4'b0000, 4'b0000);
    repeat (6) cycle("abort_set");
    drive(4'b0000, 4'b0001);
    cycle("abort_clr_acc");
    drive(4'b0000, 4'b0000);
    cycle("abort_drive2");
    pulse_reset("abort_rst");
    repeat (4) cycle("abort_after");

    // Randomised traffic with occasional illegal requests and resets
    pulse_reset("rand_rst");
    for (int i = 0; i < 400; i++) begin
      rs = N'($urandom);
      rc = N'($urandom);
      if ($urandom_range(0, 19) != 0) rc = rc & ~rs;
      if ($urandom_range(0, 3) == 0) begin
        rs = '0;
        rc = '0;
      end
      drive(rs, rc);
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_rst");
      else                            cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
